mem_stage: RTL and testbench

- Memory-access stage of the 5-stage MIPS pipeline. Sits between the execute stage and write-back.
- Takes the execute-to-memory bus and the synchronous data SRAM read data. Produces the load result, register-file byte strobes (LWL/LWR merging) and the stage's stall/forward buses.
- Holds SRAM read data across write-back back-pressure and reports exception/ERET state back to the execute stage.

---
 rtl/mem_stage.sv | 182 ++++++++++++++++++
 tb/tb_mem_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage -- memory-access stage of the 5-stage MIPS pipeline.
//
// Sits between execute and write-back. Latches the execute-to-memory bus,
// extracts load data from the synchronous data SRAM (including LWL/LWR
// byte-strobe merging), and feeds stall/forward information back upstream.
// The SRAM read data is only valid in the first cycle an instruction sits
// here, so it is captured and replayed while write-back applies back-pressure.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   flush               exception/ERET flush from write-back; kills the stage
//   ws_allowin          write-back can accept
//   ms_allowin          this stage can accept
//   es_to_ms_valid/bus  instruction offered by execute (ES_TO_MS_BUS_WD bits)
//   data_sram_rdata     SRAM read data, valid in the instruction's first cycle
//   ms_to_ws_valid/bus  instruction offered to write-back (MS_TO_WS_BUS_WD bits)
//   stall_ms_bus        {5{write enable}}, dest -- for upstream hazard checks
//   forward_ms_bus      {fwd_valid, final_result}
//   ms_exc_eret         stage holds an excepting or ERET instruction
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 104,
  parameter int MS_TO_WS_BUS_WD = 94
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [9:0]                 stall_ms_bus,
  output logic [32:0]                forward_ms_bus,
  output logic                       ms_exc_eret
);

  logic                       ms_valid;
  logic                       ms_ready_go;
  logic                       es_accept;
  logic [ES_TO_MS_BUS_WD-1:0] bus_r;
  logic                       first_cycle;
  logic [31:0]                rdata_hold;
  logic [31:0]                rdata;

  // Decoded fields of the latched execute bus.
  logic        bd;
  logic        exc;
  logic [7:0]  exc_type;
  logic        eret_flush;
  logic        cp0_wen;
  logic        res_from_cp0;
  logic [7:0]  cp0_addr;
  logic        res_from_mem;
  logic [6:0]  inst_load;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;

  // The load extension-op field is carried on the bus but not needed here.
  logic        unused_ld_extd_op;

  assign bd           = bus_r[103];
  assign exc          = bus_r[102];
  assign exc_type     = bus_r[101:94];
  assign eret_flush   = bus_r[93];
  assign cp0_wen      = bus_r[92];
  assign res_from_cp0 = bus_r[91];
  assign cp0_addr     = bus_r[90:83];
  assign res_from_mem = bus_r[82];
  assign inst_load    = bus_r[81:75];
  assign gr_we        = bus_r[69];
  assign dest         = bus_r[68:64];
  assign alu_result   = bus_r[63:32];
  assign pc           = bus_r[31:0];
  assign unused_ld_extd_op = ^bus_r[74:70];

  // inst_load one-hot positions.
  logic ld_lw, ld_lb, ld_lbu, ld_lh, ld_lhu, ld_lwl, ld_lwr;
  assign {ld_lw, ld_lb, ld_lbu, ld_lh, ld_lhu, ld_lwl, ld_lwr} = inst_load;

  // ---------------------------------------------------------------- handshake
  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign es_accept      = es_to_ms_valid && ms_allowin;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ms_valid    <= 1'b0;
      first_cycle <= 1'b0;
    end else begin
      if (ms_allowin) ms_valid <= es_to_ms_valid;
      // High only for the cycle right after an accept: the SRAM answer is live.
      first_cycle <= es_accept;
    end
  end

  // NOTE: payload registers carry no reset; ms_valid qualifies everything
  // downstream, so their contents are don't-care while the stage is empty.
  always_ff @(posedge clk) begin
    if (es_accept)   bus_r      <= es_to_ms_bus;
    if (first_cycle) rdata_hold <= data_sram_rdata;
  end

  // Live SRAM data in the first cycle, the captured copy under back-pressure.
  assign rdata = first_cycle ? data_sram_rdata : rdata_hold;

  // ------------------------------------------------------------ load extract
  logic [1:0]  addr_lo;
  logic [31:0] byte_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result;
  logic [3:0]  ld_mask;

  assign addr_lo    = alu_result[1:0];
  assign byte_shift = rdata >> {addr_lo, 3'b000};
  assign ld_byte    = byte_shift[7:0];
  assign ld_half    = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // NOTE: every output of this block gets a default first, so no path
  // through the if/case leaves a value unassigned (no inferred latch).
  always_comb begin
    ld_result = rdata;
    ld_mask   = 4'b1111;
    if (ld_lb) begin
      ld_result = {{24{ld_byte[7]}}, ld_byte};
    end else if (ld_lbu) begin
      ld_result = {24'd0, ld_byte};
    end else if (ld_lh) begin
      ld_result = {{16{ld_half[15]}}, ld_half};
    end else if (ld_lhu) begin
      ld_result = {16'd0, ld_half};
    end else if (ld_lwl) begin
      // Unaligned-left: memory bytes land in the upper register lanes.
      case (addr_lo)
        2'd0:    begin ld_result = rdata << 24; ld_mask = 4'b1000; end
        2'd1:    begin ld_result = rdata << 16; ld_mask = 4'b1100; end
        2'd2:    begin ld_result = rdata << 8;  ld_mask = 4'b1110; end
        default: begin ld_result = rdata;       ld_mask = 4'b1111; end
      endcase
    end else if (ld_lwr) begin
      // Unaligned-right: memory bytes land in the lower register lanes.
      case (addr_lo)
        2'd0:    begin ld_result = rdata;       ld_mask = 4'b1111; end
        2'd1:    begin ld_result = rdata >> 8;  ld_mask = 4'b0111; end
        2'd2:    begin ld_result = rdata >> 16; ld_mask = 4'b0011; end
        default: begin ld_result = rdata >> 24; ld_mask = 4'b0001; end
      endcase
    end else if (ld_lw) begin
      ld_result = rdata;
    end
  end

  // ----------------------------------------------------------------- outputs
  logic [31:0] final_result;
  logic [3:0]  rf_we;
  logic        fwd_valid;
  logic        we_valid;

  assign final_result = res_from_mem ? ld_result : alu_result;
  assign rf_we        = ms_valid
                        ? ({4{gr_we && !exc}} & (res_from_mem ? ld_mask : 4'b1111))
                        : 4'b0000;

  // Partial-word loads (LWL/LWR) and CP0 reads cannot be forwarded from here;
  // upstream stalls on them via stall_ms_bus instead.
  assign fwd_valid = ms_valid && gr_we && !res_from_cp0 && !ld_lwl && !ld_lwr;
  assign we_valid  = ms_valid && gr_we;

  assign ms_to_ws_bus   = {bd, exc, exc_type, eret_flush, cp0_wen, res_from_cp0,
                           cp0_addr, rf_we, dest, final_result, pc};
  assign stall_ms_bus   = {{5{we_valid}}, dest};
  assign forward_ms_bus = {fwd_valid, final_result};
  assign ms_exc_eret    = ms_valid && (exc || eret_flush);

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a table of load/ALU vectors streamed
// through the stage, plus hand-written back-pressure, flush and reset
// sequences. Expected write-back traffic goes through a scoreboard queue.
module tb_mem_stage;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [103:0] es_to_ms_bus;
  logic [31:0]  data_sram_rdata;
  logic         ms_to_ws_valid;
  logic [93:0]  ms_to_ws_bus;
  logic [9:0]   stall_ms_bus;
  logic [32:0]  forward_ms_bus;
  logic         ms_exc_eret;

  mem_stage #(.ES_TO_MS_BUS_WD(104), .MS_TO_WS_BUS_WD(94)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .ws_allowin      (ws_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_rdata (data_sram_rdata),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .stall_ms_bus    (stall_ms_bus),
    .forward_ms_bus  (forward_ms_bus),
    .ms_exc_eret     (ms_exc_eret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer  = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // inst_load encodings {lw, lb, lbu, lh, lhu, lwl, lwr}
  localparam logic [6:0] IL_NONE = 7'b0000000;
  localparam logic [6:0] IL_LW   = 7'b1000000;
  localparam logic [6:0] IL_LB   = 7'b0100000;
  localparam logic [6:0] IL_LBU  = 7'b0010000;
  localparam logic [6:0] IL_LH   = 7'b0001000;
  localparam logic [6:0] IL_LHU  = 7'b0000100;
  localparam logic [6:0] IL_LWL  = 7'b0000010;
  localparam logic [6:0] IL_LWR  = 7'b0000001;

  // hi = {bd, exc, exc_type[7:0], eret_flush, cp0_wen, res_from_cp0, cp0_addr[7:0]}
  typedef struct {
    logic [20:0] hi;
    logic        mem;
    logic [6:0]  il;
    logic        gr;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [31:0] res;
    logic [3:0]  we;
    logic        fwd;
    logic        ee;
  } vec_t;

  typedef struct {
    logic [93:0] bus;
    logic        fwd;
  } exp_t;

  exp_t sb[$];

  function automatic logic [103:0] mk_bus(input logic [20:0] hi, input logic mem,
                                          input logic [6:0] il, input logic gr,
                                          input logic [4:0] dest, input logic [31:0] alu,
                                          input logic [31:0] pc);
    return {hi, mem, il, 5'b10101, gr, dest, alu, pc};
  endfunction

  // Scoreboard: compare every write-back transfer against the queue head.
  always @(negedge clk) begin
    if (!reset && ms_to_ws_valid === 1'b1 && ws_allowin) begin
      n_xfer++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got transfer pc %h expected none", ms_to_ws_bus[31:0]);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ws_bus", {34'd0, ms_to_ws_bus}, {34'd0, e.bus});
        check("fwd_bus", {95'd0, forward_ms_bus}, {95'd0, e.fwd, e.bus[63:32]});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  vec_t vec[20];

  initial begin
    vec[0]  = '{21'h0,      1'b1, IL_LB,   1'b1, 32'h10000003, 32'h80112233, 32'hFFFFFF80, 4'hF, 1'b1, 1'b0};
    vec[1]  = '{21'h0,      1'b1, IL_LBU,  1'b1, 32'h10000003, 32'h80112233, 32'h00000080, 4'hF, 1'b1, 1'b0};
    vec[2]  = '{21'h0,      1'b1, IL_LH,   1'b1, 32'h10000002, 32'h80017FFF, 32'hFFFF8001, 4'hF, 1'b1, 1'b0};
    vec[3]  = '{21'h0,      1'b1, IL_LHU,  1'b1, 32'h10000002, 32'h80017FFF, 32'h00008001, 4'hF, 1'b1, 1'b0};
    vec[4]  = '{21'h0,      1'b1, IL_LWL,  1'b1, 32'h10000001, 32'hAABBCCDD, 32'hCCDD0000, 4'hC, 1'b0, 1'b0};
    vec[5]  = '{21'h0,      1'b1, IL_LWR,  1'b1, 32'h10000002, 32'hAABBCCDD, 32'h0000AABB, 4'h3, 1'b0, 1'b0};
    vec[6]  = '{21'h0005A,  1'b1, IL_LW,   1'b1, 32'h10000000, 32'h12345678, 32'h12345678, 4'hF, 1'b1, 1'b0};
    vec[7]  = '{21'h0,      1'b1, IL_LB,   1'b1, 32'h10000000, 32'h80112233, 32'h00000033, 4'hF, 1'b1, 1'b0};
    vec[8]  = '{21'h0,      1'b1, IL_LH,   1'b1, 32'h10000000, 32'h80017FFF, 32'h00007FFF, 4'hF, 1'b1, 1'b0};
    vec[9]  = '{21'h0,      1'b1, IL_LWL,  1'b1, 32'h10000000, 32'hAABBCCDD, 32'hDD000000, 4'h8, 1'b0, 1'b0};
    vec[10] = '{21'h0,      1'b1, IL_LWL,  1'b1, 32'h10000003, 32'hAABBCCDD, 32'hAABBCCDD, 4'hF, 1'b0, 1'b0};
    vec[11] = '{21'h0,      1'b1, IL_LWR,  1'b1, 32'h10000000, 32'hAABBCCDD, 32'hAABBCCDD, 4'hF, 1'b0, 1'b0};
    vec[12] = '{21'h0,      1'b1, IL_LWR,  1'b1, 32'h10000003, 32'hAABBCCDD, 32'h000000AA, 4'h1, 1'b0, 1'b0};
    vec[13] = '{21'h0,      1'b1, IL_LB,   1'b1, 32'h10000001, 32'h0000F100, 32'hFFFFFFF1, 4'hF, 1'b1, 1'b0};
    vec[14] = '{21'h0,      1'b0, IL_NONE, 1'b1, 32'h1234ABCD, 32'hDEADBEEF, 32'h1234ABCD, 4'hF, 1'b1, 1'b0};
    vec[15] = '{21'h0,      1'b0, IL_NONE, 1'b0, 32'h00000040, 32'hDEADBEEF, 32'h00000040, 4'h0, 1'b0, 1'b0};
    vec[16] = '{21'h82000,  1'b1, IL_LW,   1'b1, 32'h10000000, 32'h12345678, 32'h12345678, 4'h0, 1'b1, 1'b1};
    vec[17] = '{21'h00400,  1'b0, IL_NONE, 1'b0, 32'h00000000, 32'h0,        32'h00000000, 4'h0, 1'b0, 1'b1};
    vec[18] = '{21'h00160,  1'b0, IL_NONE, 1'b1, 32'h00000000, 32'h0,        32'h00000000, 4'hF, 1'b0, 1'b0};
    vec[19] = '{21'h100000, 1'b1, IL_LHU,  1'b1, 32'h10000000, 32'h0000FFFF, 32'h0000FFFF, 4'hF, 1'b1, 1'b0};

    reset = 1'b1; flush = 1'b0; ws_allowin = 1'b1;
    es_to_ms_valid = 1'b0; es_to_ms_bus = '0; data_sram_rdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_ms_to_ws_valid", {127'd0, ms_to_ws_valid}, 128'd0);
    check("rst_ms_allowin", {127'd0, ms_allowin}, 128'd1);
    check("rst_stall_en", {123'd0, stall_ms_bus[9:5]}, 128'd0);
    check("rst_fwd_valid", {127'd0, forward_ms_bus[32]}, 128'd0);
    check("rst_exc_eret", {127'd0, ms_exc_eret}, 128'd0);
    check("rst_rf_we", {124'd0, ms_to_ws_bus[72:69]}, 128'd0);

    // Table vectors, one instruction at a time.
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      logic [31:0] pc;
      logic [4:0]  dest;
      exp_t e;
      pc   = 32'hBFC0_0000 + 32'(i * 4);
      dest = 5'(i + 1);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_bus(vec[i].hi, vec[i].mem, vec[i].il, vec[i].gr, dest, vec[i].alu, pc);
      e.bus = {vec[i].hi, vec[i].we, dest, vec[i].res, pc};
      e.fwd = vec[i].fwd;
      sb.push_back(e);
      @(posedge clk); #1;
      es_to_ms_valid  = 1'b0;
      data_sram_rdata = vec[i].rd;
      @(negedge clk);
      check($sformatf("exc_eret_%0d", i), {127'd0, ms_exc_eret}, {127'd0, vec[i].ee});
      @(posedge clk); #1;
      data_sram_rdata = 32'h0BAD0BAD;
    end

    // Load held across three back-pressure cycles while SRAM data changes.
    begin
      exp_t e;
      ws_allowin     = 1'b0;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_bus(21'h0, 1'b1, IL_LW, 1'b1, 5'd7, 32'h20000000, 32'hBFC01000);
      e.bus = {21'h0, 4'hF, 5'd7, 32'h12345678, 32'hBFC01000};
      e.fwd = 1'b1;
      sb.push_back(e);
      @(posedge clk); #1;
      es_to_ms_valid  = 1'b0;
      data_sram_rdata = 32'h12345678;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check($sformatf("stall_valid_%0d", k), {127'd0, ms_to_ws_valid}, 128'd1);
        check($sformatf("stall_result_%0d", k), {96'd0, ms_to_ws_bus[63:32]}, {96'd0, 32'h12345678});
        @(posedge clk); #1;
        data_sram_rdata = 32'hDEADBEEF;
      end
      ws_allowin = 1'b1;
      @(posedge clk); #1;
    end

    // Flush coinciding with an offered instruction: nothing enters.
    flush          = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(21'h0, 1'b0, IL_NONE, 1'b1, 5'd3, 32'h1, 32'hBFC02000);
    @(posedge clk); #1;
    flush = 1'b0; es_to_ms_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", {127'd0, ms_to_ws_valid}, 128'd0);
    check("flush_allowin", {127'd0, ms_allowin}, 128'd1);
    @(posedge clk); #1;

    // Reset asserted while an instruction is stalled in the stage.
    ws_allowin     = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(21'h82000, 1'b0, IL_NONE, 1'b1, 5'd9, 32'h55, 32'hBFC03000);
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", {127'd0, ms_to_ws_valid}, 128'd1);
    check("pre_rst_allowin", {127'd0, ms_allowin}, 128'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {127'd0, ms_to_ws_valid}, 128'd0);
    check("mid_rst_allowin", {127'd0, ms_allowin}, 128'd1);
    check("mid_rst_stall_en", {123'd0, stall_ms_bus[9:5]}, 128'd0);
    check("mid_rst_fwd", {127'd0, forward_ms_bus[32]}, 128'd0);
    check("mid_rst_rf_we", {124'd0, ms_to_ws_bus[72:69]}, 128'd0);
    check("mid_rst_exc_eret", {127'd0, ms_exc_eret}, 128'd0);
    @(posedge clk); #1;
    ws_allowin = 1'b1;

    // Back-to-back ALU ops: one write-back transfer per cycle.
    begin
      int xfer0;
      xfer0 = n_xfer;
      for (int i = 0; i < 4; i++) begin
        exp_t e;
        logic [31:0] alu;
        alu = 32'hA000_0000 + 32'(i * 17);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(21'h0, 1'b0, IL_NONE, 1'b1, 5'(20 + i), alu, 32'hBFC04000 + 32'(i * 4));
        e.bus = {21'h0, 4'hF, 5'(20 + i), alu, 32'hBFC04000 + 32'(i * 4)};
        e.fwd = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        check($sformatf("b2b_allowin_%0d", i), {127'd0, ms_allowin}, 128'd1);
        @(posedge clk); #1;
      end
      es_to_ms_valid = 1'b0;
      @(negedge clk); #1;
      check("b2b_xfers", 128'(n_xfer - xfer0), 128'd4);
    end

    @(posedge clk); #1;
    check("sb_drained", 128'(sb.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
